gauss_filter: RTL and testbench

Memory-mapped 1-D Gaussian smoothing peripheral that sits directly behind the Gauss address decoder on the RISC-V uniciclo data bus. The decoder's `select` output steers core loads and stores to one of two registers: CTRL/STATUS at offset 0x30 or DATA at offset 0x34. Samples written to DATA pass through a 5-tap [1,4,6,4,1]/16 kernel computed by a sequential multiply-accumulate engine. Results are queued in a 4-entry output FIFO that the core drains by reading DATA.

---
 rtl/gauss_pkg.sv | 27 ++
 rtl/gauss_fifo.sv | 55 +++++
 rtl/gauss_filter.sv | 160 ++++++++++++++++
 tb/tb_gauss_filter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared types and constants for the Gaussian smoothing peripheral:
// FSM states, kernel taps, register bit positions and result rounding.
package gauss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_PUSH = 2'd2
    } state_e;

    localparam int NTAPS = 5;
    localparam logic [2:0] COEF [NTAPS] = '{3'd1, 3'd4, 3'd6, 3'd4, 3'd1};

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CLR   = 1;

    localparam int STAT_EN    = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_OVLD  = 2;
    localparam int STAT_IRDY  = 3;
    localparam int STAT_CNT   = 4;
    localparam int STAT_OVF   = 7;

    localparam int RND_CONST  = 8;
    localparam int RND_SHIFT  = 4;

endpackage

// File: rtl/gauss_fifo.sv
// Synchronous result FIFO with combinational head, occupancy count and flush.
// A pop on a full FIFO frees the slot for a simultaneous push.
module gauss_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             din_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !flush_i) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/gauss_filter.sv
// Memory-mapped 5-tap [1,4,6,4,1]/16 smoothing filter: CTRL/STATUS and DATA
// registers, sequential MAC engine and an output FIFO drained by DATA reads.
module gauss_filter
    import gauss_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic        select_i,
    input  logic        we_i,
    input  logic        rd_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    localparam int ACC_W = SAMPLE_W + 4;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [SAMPLE_W-1:0] round_result(input logic [ACC_W-1:0] acc);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W + 1)'(RND_CONST);
        return sum[RND_SHIFT +: SAMPLE_W];
    endfunction

    state_e                state_q, state_d;
    logic                  en_q, en_d;
    logic                  ovf_q, ovf_d;
    logic [SAMPLE_W-1:0]   win_q [NTAPS];
    logic [SAMPLE_W-1:0]   win_d [NTAPS];
    logic [2:0]            nsamp_q, nsamp_d;
    logic [2:0]            k_q, k_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      prod;

    logic                  ctrl_wr, clr, data_wr, data_rd, idle, in_ready, accept;
    logic                  fifo_push, fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0]   fifo_head;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [31:0]           status, data_word;
    logic                  unused_wdata;

    assign unused_wdata = ^{wdata_i[31:SAMPLE_W]};

    assign ctrl_wr  = cs_i & we_i & ~select_i;
    assign clr      = ctrl_wr & wdata_i[CTRL_CLR];
    assign data_wr  = cs_i & we_i & select_i;
    assign data_rd  = cs_i & rd_i & select_i;
    assign idle     = (state_q == ST_IDLE);
    assign in_ready = en_q & idle;
    assign accept   = data_wr & in_ready;

    assign prod = ACC_W'(win_q[k_q]) * ACC_W'(COEF[k_q]);

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        ovf_d     = ovf_q;
        win_d     = win_q;
        nsamp_d   = nsamp_q;
        k_d       = k_q;
        acc_d     = acc_q;
        fifo_push = 1'b0;

        if (ctrl_wr) en_d = wdata_i[CTRL_EN];

        // CLR wins over everything, including an in-flight MAC or PUSH.
        if (clr) begin
            state_d = ST_IDLE;
            ovf_d   = 1'b0;
            nsamp_d = '0;
            for (int i = 0; i < NTAPS; i++) win_d[i] = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        win_d[0] = wdata_i[SAMPLE_W-1:0];
                        for (int i = 1; i < NTAPS; i++) win_d[i] = win_q[i-1];
                        nsamp_d = (nsamp_q == 3'(NTAPS)) ? nsamp_q : nsamp_q + 3'd1;
                        if (nsamp_d == 3'(NTAPS)) begin
                            state_d = ST_MAC;
                            k_d     = '0;
                            acc_d   = '0;
                        end
                    end
                end
                ST_MAC: begin
                    acc_d = acc_q + prod;
                    k_d   = k_q + 3'd1;
                    if (k_q == 3'(NTAPS - 1)) state_d = ST_PUSH;
                end
                ST_PUSH: begin
                    fifo_push = 1'b1;
                    if (fifo_full && !data_rd) ovf_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (data_wr && en_q && !idle) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
            nsamp_q <= '0;
            k_q     <= '0;
            for (int i = 0; i < NTAPS; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            nsamp_q <= nsamp_d;
            k_q     <= k_d;
            win_q   <= win_d;
        end
    end

    always_ff @(posedge clk_i) begin
        acc_q <= acc_d;
    end

    gauss_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clr),
        .push_i  (fifo_push),
        .pop_i   (data_rd),
        .din_i   (round_result(acc_q)),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        status                  = '0;
        status[STAT_EN]         = en_q;
        status[STAT_BUSY]       = ~idle;
        status[STAT_OVLD]       = ~fifo_empty;
        status[STAT_IRDY]       = in_ready;
        status[STAT_CNT +: 3]   = 3'(fifo_cnt);
        status[STAT_OVF]        = ovf_q;

        data_word = '0;
        if (!fifo_empty) data_word[SAMPLE_W-1:0] = fifo_head;

        if (!cs_i)         rdata_o = '0;
        else if (select_i) rdata_o = data_word;
        else               rdata_o = status;
    end

endmodule

// File: tb/tb_gauss_filter.sv
// Directed bench for gauss_filter with a reference window/FIFO model and a
// scoreboard queue of expected results compared against DATA reads.
module tb_gauss_filter;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        cs    = 1'b0;
    logic        sel   = 1'b0;
    logic        we    = 1'b0;
    logic        rd    = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_q[$];
    int mwin[5];
    int mcnt  = 0;
    bit m_en  = 1'b0;
    bit m_ovf = 1'b0;

    always #5 clk = ~clk;

    gauss_filter #(.FIFO_DEPTH(4), .SAMPLE_W(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cs_i     (cs),
        .select_i (sel),
        .we_i     (we),
        .rd_i     (rd),
        .wdata_i  (wdata),
        .rdata_o  (rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clr();
        for (int i = 0; i < 5; i++) mwin[i] = 0;
        mcnt  = 0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int v);
        int r;
        for (int i = 4; i > 0; i--) mwin[i] = mwin[i-1];
        mwin[0] = v & 255;
        if (mcnt < 5) mcnt++;
        if (mcnt == 5) begin
            r = (mwin[0] + 4*mwin[1] + 6*mwin[2] + 4*mwin[3] + mwin[4] + 8) / 16;
            if (exp_q.size() < 4) exp_q.push_back(r);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = m_en;
        s[2]   = (exp_q.size() > 0);
        s[3]   = m_en;
        s[6:4] = 3'(exp_q.size());
        s[7]   = m_ovf;
        return s;
    endfunction

    // All bus tasks are entered right after a falling edge.
    task automatic wr_ctrl(input logic [31:0] v);
        cs = 1'b1; we = 1'b1; sel = 1'b0; wdata = v;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic wr_data(input int v);
        cs = 1'b1; we = 1'b1; sel = 1'b1; wdata = 32'(v);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; sel = 1'b0; wdata = '0;
    endtask

    task automatic rd_status(output logic [31:0] s);
        cs = 1'b1; sel = 1'b0; rd = 1'b1;
        #1 s = rdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_data_chk(input string tag);
        int e;
        cs = 1'b1; sel = 1'b1; rd = 1'b1;
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        check(tag, rdata, 32'(e));
        @(negedge clk);
        cs = 1'b0; sel = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        s = '1;
        for (int i = 0; i < 20; i++) begin
            rd_status(s);
            if (!s[1]) break;
            @(negedge clk);
        end
        check(tag, {31'b0, s[1]}, 32'd0);
    endtask

    task automatic push_sample(input int v, input string tag);
        wr_data(v);
        model_accept(v);
        wait_idle(tag);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] s;
        rd_status(s);
        check(tag, s, exp_status());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] s;
        model_clr();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and empty-FIFO read
        check("reset_status", 32'(0), 32'(0) | exp_status());
        check_status("reset_status_rd");
        rd_data_chk("reset_data_rd");
        check_status("reset_cnt_after_rd");

        // Data write with EN=0 is ignored
        wr_data(55);
        @(negedge clk);
        check_status("en0_write_ignored");

        // Constant 100 stream, result latency
        wr_ctrl(32'h1);
        m_en = 1'b1;
        check_status("en_status");
        for (int i = 0; i < 4; i++) push_sample(100, "fill100_idle");
        check_status("no_result_before_full");
        wr_data(100);
        model_accept(100);
        for (int c = 0; c < 6; c++) begin
            rd_status(s);
            check($sformatf("busy_cycle%0d", c), {30'b0, s[2:1]}, 32'b01);
            @(negedge clk);
        end
        check_status("ovalid_at_t6");
        rd_data_chk("data100");
        check_status("count_back_to0");

        // Impulse response
        wr_ctrl(32'h3);
        model_clr();
        check_status("clr_status");
        push_sample(0, "imp0"); push_sample(0, "imp1"); push_sample(0, "imp2");
        push_sample(0, "imp3"); push_sample(255, "imp4");
        push_sample(0, "imp5"); push_sample(0, "imp6");
        check_status("imp_count3");
        rd_data_chk("imp_r0");
        rd_data_chk("imp_r1");
        rd_data_chk("imp_r2");

        // Five results without draining: overflow
        wr_ctrl(32'h3);
        model_clr();
        for (int i = 1; i <= 9; i++) push_sample(i * 27, "ovf_fill");
        check_status("ovf_full_status");
        for (int i = 0; i < 4; i++) rd_data_chk("ovf_drain");
        check_status("ovf_sticky");

        // Write while busy sets overflow
        wr_ctrl(32'h3);
        model_clr();
        check_status("clr_clears_ovf");
        for (int i = 0; i < 4; i++) push_sample(200 - i * 13, "busy_fill");
        wr_data(17);
        model_accept(17);
        wr_data(99);
        m_ovf = 1'b1;
        wait_idle("busy_wr_idle");
        check_status("busy_write_ovf");
        rd_data_chk("busy_result");

        // Push coincides with pop on a full FIFO
        wr_ctrl(32'h3);
        model_clr();
        for (int i = 0; i < 8; i++) push_sample((i * 71 + 5) & 255, "pp_fill");
        check_status("pp_full");
        wr_data(240);
        repeat (5) @(negedge clk);
        rd_data_chk("pp_pop_in_push");
        model_accept(240);
        check_status("pp_count4_no_ovf");
        for (int i = 0; i < 4; i++) rd_data_chk("pp_drain");

        // CLR during MAC aborts the result
        wr_ctrl(32'h3);
        model_clr();
        for (int i = 0; i < 4; i++) push_sample(150, "abort_fill");
        wr_data(150);
        wr_ctrl(32'h3);
        model_clr();
        repeat (8) @(negedge clk);
        rd_status(s);
        check("abort_status_09", s, 32'h09);
        push_sample(1, "re0"); push_sample(2, "re1");
        push_sample(3, "re2"); push_sample(4, "re3");
        check_status("abort_needs_five");
        push_sample(200, "re4");
        check_status("abort_new_result");

        // Read with cs low: zero, no pop
        sel = 1'b1; rd = 1'b1;
        #1 check("nocs_rdata", rdata, 32'd0);
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
        rd_data_chk("after_nocs_read");
        check_status("final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
